// File: rtl/bmw_pop_monitor.sv
// Pop-side checker for a min-priority queue: tracks occupancy, classifies push/pop requests and
// verifies that every popped priority respects the lower bound implied by the traffic seen so far.
module bmw_pop_monitor #(
    parameter int PTW      = 16,
    parameter int MTW      = 17,
    parameter int CTW      = 17,
    parameter int CAPACITY = 87380,
    parameter int POP_LAT  = 2,
    parameter int CNTW     = 32
) (
    input  logic                 i_clk,
    input  logic                 i_arst_n,
    input  logic                 i_push,
    input  logic [MTW+PTW-1:0]   i_push_data,
    input  logic                 i_pop,
    input  logic [MTW+PTW-1:0]   i_pop_data,
    output logic [CTW-1:0]       o_occupancy,
    output logic [1:0]           o_state,
    output logic [CNTW-1:0]      o_pop_count,
    output logic [CNTW-1:0]      o_err_count,
    output logic                 o_err_underflow,
    output logic                 o_err_overflow,
    output logic                 o_err_collide,
    output logic                 o_err_order,
    output logic [MTW+PTW-1:0]   o_first_err_data
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CTW-1:0]   occ_q;
    logic [CTW-1:0]   occ_d;
    logic [PTW-1:0]   lb_q;
    logic [PTW-1:0]   lb_d;

    logic [POP_LAT-1:0] pipe_v_q;
    logic [PTW-1:0]     pipe_s_q [POP_LAT];

    logic             collide;
    logic             underflow;
    logic             overflow;
    logic             legal_push;
    logic             legal_pop;
    logic             exit_valid;
    logic [PTW-1:0]   exit_snap;
    logic [PTW-1:0]   push_prio;
    logic [PTW-1:0]   pop_prio;
    logic             order_err;
    logic [1:0]       err_inc;
    logic [CNTW:0]    err_sum;
    logic [CNTW-1:0]  err_count_d;
    logic [CNTW-1:0]  pop_count_d;

    logic unused_push_meta;
    assign unused_push_meta = ^i_push_data[MTW+PTW-1:PTW];

    assign push_prio  = i_push_data[PTW-1:0];
    assign pop_prio   = i_pop_data[PTW-1:0];

    // A simultaneous push and pop is illegal, so neither request is applied in that cycle.
    assign collide    = i_push & i_pop;
    assign underflow  = i_pop & ~i_push & (state_q == ST_EMPTY);
    assign overflow   = i_push & ~i_pop & (state_q == ST_FULL);
    assign legal_push = i_push & ~i_pop & (state_q != ST_FULL);
    assign legal_pop  = i_pop & ~i_push & (state_q != ST_EMPTY);

    assign exit_valid = pipe_v_q[POP_LAT-1];
    assign exit_snap  = pipe_s_q[POP_LAT-1];
    assign order_err  = exit_valid & (pop_prio < exit_snap);

    always_comb begin
        occ_d   = occ_q;
        state_d = state_q;
        if (legal_push) begin
            occ_d = occ_q + CTW'(1);
        end else if (legal_pop) begin
            occ_d = occ_q - CTW'(1);
        end
        if (occ_d == '0) begin
            state_d = ST_EMPTY;
        end else if (occ_d == CTW'(CAPACITY)) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_PARTIAL;
        end
    end

    // A checked pop resets the bound to its own priority; a push landing in the same cycle may lower it.
    always_comb begin
        lb_d = lb_q;
        if (exit_valid) begin
            if (legal_push && (push_prio < pop_prio)) begin
                lb_d = push_prio;
            end else begin
                lb_d = pop_prio;
            end
        end else if (legal_push && (push_prio < lb_q)) begin
            lb_d = push_prio;
        end
    end

    always_comb begin
        err_inc     = {1'b0, collide | underflow | overflow} + {1'b0, order_err};
        err_sum     = {1'b0, o_err_count} + (CNTW+1)'(err_inc);
        err_count_d = err_sum[CNTW] ? '1 : err_sum[CNTW-1:0];
        pop_count_d = o_pop_count;
        if (exit_valid && (o_pop_count != '1)) begin
            pop_count_d = o_pop_count + CNTW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= ST_EMPTY;
            occ_q   <= '0;
            lb_q    <= '1;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            lb_q    <= lb_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            pipe_v_q <= '0;
            for (int i = 0; i < POP_LAT; i++) begin
                pipe_s_q[i] <= '0;
            end
        end else begin
            for (int i = POP_LAT-1; i > 0; i--) begin
                pipe_v_q[i] <= pipe_v_q[i-1];
                pipe_s_q[i] <= pipe_s_q[i-1];
            end
            pipe_v_q[0] <= legal_pop;
            pipe_s_q[0] <= lb_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_pop_count      <= '0;
            o_err_count      <= '0;
            o_err_underflow  <= 1'b0;
            o_err_overflow   <= 1'b0;
            o_err_collide    <= 1'b0;
            o_err_order      <= 1'b0;
            o_first_err_data <= '0;
        end else begin
            o_pop_count     <= pop_count_d;
            o_err_count     <= err_count_d;
            o_err_underflow <= o_err_underflow | underflow;
            o_err_overflow  <= o_err_overflow | overflow;
            o_err_collide   <= o_err_collide | collide;
            o_err_order     <= o_err_order | order_err;
            if (order_err && !o_err_order) begin
                o_first_err_data <= i_pop_data;
            end
        end
    end

    assign o_occupancy = occ_q;
    assign o_state     = state_q;

endmodule
